// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed matrix display path:
// scan FSM state encoding, a safe clog2 width helper and pin polarity encoding.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Translate a logical "on" bit into its pin level for the given polarity.
  function automatic logic pol_bit(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Modulo-MOD up counter with a terminal-count pulse and synchronous clear,
// used for the per-row dwell and the inter-row blanking intervals.
module scan_timer #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = inc && (cnt == W'(MOD - 1));

  // Count register: wraps to zero on terminal count, clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed ROWS x COLS LED matrix driver with tear-free frame latching,
// per-row dwell, anti-ghost blanking and pin polarity. Optional MATRIX_SCAN_DIMMING_EN adds PWM duty.
module matrix_scan_driver #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DWELL          = 1,
  parameter int BLANK          = 0,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 0,
  localparam int RW = display_pkg::clog2w(ROWS),
  localparam int DW = display_pkg::clog2w(DWELL + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [ROWS*COLS-1:0]   pixels,
`ifdef MATRIX_SCAN_DIMMING_EN
  input  logic [DW-1:0]          duty,
`endif
  output logic [ROWS-1:0]        row_pins,
  output logic [COLS-1:0]        col_pins,
  output logic [RW-1:0]          row_idx,
  output logic                   frame_tick
);
  import display_pkg::*;

  localparam logic [1:0] ST_IDLE  = display_pkg::IDLE;
  localparam logic [1:0] ST_DRIVE = display_pkg::DRIVE;
  localparam logic [1:0] ST_BLANK = display_pkg::BLANK;

  localparam logic ROW_OFF = (ROW_ACTIVE_LOW != 0);
  localparam logic COL_OFF = (COL_ACTIVE_LOW != 0);

  localparam int TW = clog2w(DWELL);
  localparam int BW = clog2w((BLANK > 0) ? BLANK : 1);

  logic [1:0]           state;
  logic [1:0]           state_n;
  logic [RW-1:0]        row_n;
  logic [ROWS*COLS-1:0] shadow;
  logic [ROWS*COLS-1:0] shadow_n;
  logic                 tick_n;
  logic                 adv_s;
  logic                 lit_s;
  logic                 drive_n;
  logic [COLS-1:0]      row_bits_s;
  logic [ROWS-1:0]      row_vec_s;
  logic [COLS-1:0]      col_vec_s;

  logic                 dwell_inc;
  logic                 dwell_clr;
  logic                 dwell_tc;
  logic [TW-1:0]        dwell_cnt;
  logic                 blank_inc;
  logic                 blank_clr;
  logic                 blank_tc;
  logic [BW-1:0]        blank_cnt_unused;

  scan_timer #(.MOD(DWELL), .W(TW)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (dwell_clr),
    .inc (dwell_inc),
    .cnt (dwell_cnt),
    .tc  (dwell_tc)
  );

  scan_timer #(.MOD((BLANK > 0) ? BLANK : 1), .W(BW)) u_blank (
    .clk (clk),
    .rst (rst),
    .clr (blank_clr),
    .inc (blank_inc),
    .cnt (blank_cnt_unused),
    .tc  (blank_tc)
  );

`ifdef MATRIX_SCAN_DIMMING_EN
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_n;
  logic [TW-1:0] dwell_nxt;
`else
  logic dwell_cnt_unused;
  assign dwell_cnt_unused = ^dwell_cnt;
`endif

  // Next-state, row advance and frame latch decisions.
  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    shadow_n  = shadow;
    tick_n    = 1'b0;
    adv_s     = 1'b0;
    dwell_inc = 1'b0;
    dwell_clr = 1'b0;
    blank_inc = 1'b0;
    blank_clr = 1'b0;
`ifdef MATRIX_SCAN_DIMMING_EN
    duty_n    = duty_r;
`endif
    if (!en) begin
      state_n   = ST_IDLE;
      row_n     = '0;
      shadow_n  = '0;
      dwell_clr = 1'b1;
      blank_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n   = ST_DRIVE;
          row_n     = '0;
          shadow_n  = pixels;
          tick_n    = 1'b1;
          dwell_clr = 1'b1;
          blank_clr = 1'b1;
`ifdef MATRIX_SCAN_DIMMING_EN
          duty_n    = duty;
`endif
        end
        ST_DRIVE: begin
          dwell_inc = 1'b1;
          if (dwell_tc && (BLANK > 0)) begin
            state_n = ST_BLANK;
          end else if (dwell_tc) begin
            adv_s = 1'b1;
          end else begin
            state_n = ST_DRIVE;
          end
        end
        ST_BLANK: begin
          blank_inc = 1'b1;
          if (blank_tc) begin
            state_n = ST_DRIVE;
            adv_s   = 1'b1;
          end else begin
            state_n = ST_BLANK;
          end
        end
        default: begin
          state_n   = ST_IDLE;
          row_n     = '0;
          shadow_n  = '0;
          dwell_clr = 1'b1;
          blank_clr = 1'b1;
        end
      endcase
      // Wrapping past the last row is the only place a new frame is latched mid-scan.
      if (adv_s && (row_idx == RW'(ROWS - 1))) begin
        row_n    = '0;
        shadow_n = pixels;
        tick_n   = 1'b1;
`ifdef MATRIX_SCAN_DIMMING_EN
        duty_n   = duty;
`endif
      end else if (adv_s) begin
        row_n = row_idx + RW'(1);
      end else begin
        row_n = row_n;
      end
    end
  end

  // Pin levels for the upcoming cycle, derived from the next state so they register in step.
  always_comb begin
    drive_n    = (state_n == ST_DRIVE);
    row_bits_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_n == RW'(r)) begin
        row_bits_s = shadow_n[r*COLS +: COLS];
      end else begin
        row_bits_s = row_bits_s;
      end
      row_vec_s[r] = pol_bit(drive_n && (row_n == RW'(r)), ROW_OFF);
    end
`ifdef MATRIX_SCAN_DIMMING_EN
    if (dwell_clr || dwell_tc) begin
      dwell_nxt = '0;
    end else if (dwell_inc) begin
      dwell_nxt = dwell_cnt + TW'(1);
    end else begin
      dwell_nxt = dwell_cnt;
    end
    lit_s = (DW'(dwell_nxt) < duty_n);
`else
    lit_s = 1'b1;
`endif
    for (int c = 0; c < COLS; c++) begin
      col_vec_s[c] = pol_bit(drive_n && lit_s && row_bits_s[c], COL_OFF);
    end
  end

  // State, frame shadow and registered pin outputs; reset forces pins to their off level at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      row_idx    <= '0;
      frame_tick <= 1'b0;
      row_pins   <= {ROWS{ROW_OFF}};
      col_pins   <= {COLS{COL_OFF}};
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      row_idx    <= row_n;
      frame_tick <= tick_n;
      row_pins   <= row_vec_s;
      col_pins   <= col_vec_s;
    end
  end

`ifdef MATRIX_SCAN_DIMMING_EN
  // Brightness is captured together with the frame so it changes only between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_r <= '0;
    end else begin
      duty_r <= duty_n;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: default 4x4 scan, tearing, enable drop,
// dwell/blank timing, async reset and (with MATRIX_SCAN_DIMMING_EN) PWM dimming.
module tb_matrix_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a;
  logic        en_b;
  logic [15:0] pixels;
  logic [3:0]  row_a, col_a, row_b, col_b;
  logic [1:0]  idx_a, idx_b;
  logic        tick_a, tick_b;
  int          cmp_n = 0;
  int          err_n = 0;

`ifdef MATRIX_SCAN_DIMMING_EN
  logic        en_c;
  logic [2:0]  duty_c;
  logic        duty_a = 1'b1;
  logic [1:0]  duty_b = 2'd3;
  logic [3:0]  row_c, col_c;
  logic [1:0]  idx_c;
  logic        tick_c;
`endif

  matrix_scan_driver dut_a (
    .clk(clk), .rst(rst), .en(en_a), .pixels(pixels),
`ifdef MATRIX_SCAN_DIMMING_EN
    .duty(duty_a),
`endif
    .row_pins(row_a), .col_pins(col_a), .row_idx(idx_a), .frame_tick(tick_a)
  );

  matrix_scan_driver #(.DWELL(3), .BLANK(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .pixels(pixels),
`ifdef MATRIX_SCAN_DIMMING_EN
    .duty(duty_b),
`endif
    .row_pins(row_b), .col_pins(col_b), .row_idx(idx_b), .frame_tick(tick_b)
  );

`ifdef MATRIX_SCAN_DIMMING_EN
  matrix_scan_driver #(.DWELL(4)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .pixels(pixels), .duty(duty_c),
    .row_pins(row_c), .col_pins(col_c), .row_idx(idx_c), .frame_tick(tick_c)
  );
`endif

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0; pixels = 16'hFFFF;
`ifdef MATRIX_SCAN_DIMMING_EN
    en_c = 1'b0; duty_c = 3'd2;
`endif
    #2 rst = 1'b0;
    #21;
    cmp_n++; if (row_a !== 4'b1111) begin err_n++; $display("FAIL reset_rows: got %b want %b", row_a, 4'b1111); end
    cmp_n++; if (col_a !== 4'b0000) begin err_n++; $display("FAIL reset_cols: got %b want %b", col_a, 4'b0000); end
    cmp_n++; if (tick_a !== 1'b0) begin err_n++; $display("FAIL reset_tick: got %b want 0", tick_a); end
    cmp_n++; if (idx_a !== 2'd0) begin err_n++; $display("FAIL reset_idx: got %0d want 0", idx_a); end
    cmp_n++; if (row_b !== 4'b1111) begin err_n++; $display("FAIL reset_rows_b: got %b want %b", row_b, 4'b1111); end
    cmp_n++; if (col_b !== 4'b0000) begin err_n++; $display("FAIL reset_cols_b: got %b want %b", col_b, 4'b0000); end
  endtask

  task automatic test_scan();
    logic [3:0] oh;
    @(negedge clk);
    pixels = 16'h8421;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      oh = 4'b0001 << (k % 4);
      cmp_n++; if (row_a !== ~oh) begin err_n++; $display("FAIL scan_rows[%0d]: got %b want %b", k, row_a, ~oh); end
      cmp_n++; if (col_a !== oh) begin err_n++; $display("FAIL scan_cols[%0d]: got %b want %b", k, col_a, oh); end
      cmp_n++; if (tick_a !== ((k % 4) == 0)) begin err_n++; $display("FAIL scan_tick[%0d]: got %b want %b", k, tick_a, ((k % 4) == 0)); end
      cmp_n++; if (idx_a !== 2'(k % 4)) begin err_n++; $display("FAIL scan_idx[%0d]: got %0d want %0d", k, idx_a, k % 4); end
    end
  endtask

  task automatic test_tearing();
    logic [3:0] e_col;
    logic       e_tick;
    cmp_n++; if (idx_a !== 2'd3) begin err_n++; $display("FAIL tear_start_idx: got %0d want 3", idx_a); end
    pixels = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e_col  = (k == 4) ? 4'b1111 : 4'b0000;
      e_tick = (k == 0) || (k == 4);
      cmp_n++; if (col_a !== e_col) begin err_n++; $display("FAIL tear_cols[%0d]: got %b want %b", k, col_a, e_col); end
      cmp_n++; if (tick_a !== e_tick) begin err_n++; $display("FAIL tear_tick[%0d]: got %b want %b", k, tick_a, e_tick); end
      cmp_n++; if (idx_a !== 2'(k % 4)) begin err_n++; $display("FAIL tear_idx[%0d]: got %0d want %0d", k, idx_a, k % 4); end
      if (k == 2) pixels = 16'hFFFF;
    end
    cmp_n++; if (row_a !== 4'b1110) begin err_n++; $display("FAIL tear_row0: got %b want %b", row_a, 4'b1110); end
  endtask

  task automatic test_enable_drop();
    @(negedge clk);
    cmp_n++; if (idx_a !== 2'd1) begin err_n++; $display("FAIL drop_pre_idx: got %0d want 1", idx_a); end
    cmp_n++; if (row_a !== 4'b1101) begin err_n++; $display("FAIL drop_pre_rows: got %b want %b", row_a, 4'b1101); end
    en_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmp_n++; if (row_a !== 4'b1111) begin err_n++; $display("FAIL drop_rows[%0d]: got %b want %b", k, row_a, 4'b1111); end
      cmp_n++; if (col_a !== 4'b0000) begin err_n++; $display("FAIL drop_cols[%0d]: got %b want %b", k, col_a, 4'b0000); end
      cmp_n++; if (idx_a !== 2'd0) begin err_n++; $display("FAIL drop_idx[%0d]: got %0d want 0", k, idx_a); end
      cmp_n++; if (tick_a !== 1'b0) begin err_n++; $display("FAIL drop_tick[%0d]: got %b want 0", k, tick_a); end
    end
    en_a = 1'b1;
    @(negedge clk);
    cmp_n++; if (row_a !== 4'b1110) begin err_n++; $display("FAIL resume_rows: got %b want %b", row_a, 4'b1110); end
    cmp_n++; if (col_a !== 4'b1111) begin err_n++; $display("FAIL resume_cols: got %b want %b", col_a, 4'b1111); end
    cmp_n++; if (tick_a !== 1'b1) begin err_n++; $display("FAIL resume_tick: got %b want 1", tick_a); end
    cmp_n++; if (idx_a !== 2'd0) begin err_n++; $display("FAIL resume_idx: got %0d want 0", idx_a); end
  endtask

  task automatic test_dwell_blank();
    logic [3:0] oh, e_row, e_col;
    int p, r;
    pixels = 16'hFFFF;
    en_b = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      p = t % 5;
      r = (t / 5) % 4;
      oh = 4'b0001 << r;
      e_row = (p < 3) ? ~oh : 4'b1111;
      e_col = (p < 3) ? 4'b1111 : 4'b0000;
      cmp_n++; if (row_b !== e_row) begin err_n++; $display("FAIL blank_rows[%0d]: got %b want %b", t, row_b, e_row); end
      cmp_n++; if (col_b !== e_col) begin err_n++; $display("FAIL blank_cols[%0d]: got %b want %b", t, col_b, e_col); end
      cmp_n++; if (tick_b !== ((t % 20) == 0)) begin err_n++; $display("FAIL blank_tick[%0d]: got %b want %b", t, tick_b, ((t % 20) == 0)); end
      cmp_n++; if (idx_b !== 2'(r)) begin err_n++; $display("FAIL blank_idx[%0d]: got %0d want %0d", t, idx_b, r); end
    end
    en_b = 1'b0;
  endtask

`ifdef MATRIX_SCAN_DIMMING_EN
  task automatic test_dimming();
    logic [3:0] oh, e_col;
    duty_c = 3'd2;
    pixels = 16'hFFFF;
    en_c = 1'b1;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      oh = 4'b0001 << ((t / 4) % 4);
      e_col = ((t % 4) < 2) ? 4'b1111 : 4'b0000;
      cmp_n++; if (row_c !== ~oh) begin err_n++; $display("FAIL dim_rows[%0d]: got %b want %b", t, row_c, ~oh); end
      cmp_n++; if (col_c !== e_col) begin err_n++; $display("FAIL dim_cols[%0d]: got %b want %b", t, col_c, e_col); end
      cmp_n++; if (tick_c !== ((t % 16) == 0)) begin err_n++; $display("FAIL dim_tick[%0d]: got %b want %b", t, tick_c, ((t % 16) == 0)); end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    cmp_n++; if (row_c !== 4'b1111) begin err_n++; $display("FAIL dim_async_rows: got %b want %b", row_c, 4'b1111); end
    cmp_n++; if (col_c !== 4'b0000) begin err_n++; $display("FAIL dim_async_cols: got %b want %b", col_c, 4'b0000); end
    @(negedge clk);
    rst = 1'b1;
    en_c = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    cmp_n++; if (col_a !== 4'b1111) begin err_n++; $display("FAIL async_pre_cols: got %b want %b", col_a, 4'b1111); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    cmp_n++; if (row_a !== 4'b1111) begin err_n++; $display("FAIL async_rows: got %b want %b", row_a, 4'b1111); end
    cmp_n++; if (col_a !== 4'b0000) begin err_n++; $display("FAIL async_cols: got %b want %b", col_a, 4'b0000); end
    cmp_n++; if (idx_a !== 2'd0) begin err_n++; $display("FAIL async_idx: got %0d want 0", idx_a); end
    cmp_n++; if (tick_a !== 1'b0) begin err_n++; $display("FAIL async_tick: got %b want 0", tick_a); end
    #10 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_enable_drop();
    test_dwell_blank();
`ifdef MATRIX_SCAN_DIMMING_EN
    test_dimming();
    en_a = 1'b0;
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
